duration_timer: RTL and testbench

DURATION_TIMER -- requirements
Module: duration_timer

---
 rtl/duration_timer.sv | 91 +++++++++
 tb/tb_duration_timer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/duration_timer.sv
// Prescaled countdown timer: busy while an interval runs, one-cycle co when it ends.
// Optional macro DURATION_TIMER_RETRIGGER_EN lets start reload a running interval.
module duration_timer #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned N        = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] duration,
  input  logic         hold,
  output logic         busy,
  output logic [N-1:0] remain,
  output logic         co
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [N-1:0]  remain_nx;
  logic          load;
  logic          wrap;

  assign wrap = (presc == PW'(PRESCALE - 1));

  always_comb begin
    state_nx  = state;
    remain_nx = remain;
    presc_nx  = presc;
    load      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) load = 1'b1;
        else       state_nx = IDLE;
      end
      RUN: begin
`ifdef DURATION_TIMER_RETRIGGER_EN
        if (start) load = 1'b1;
        else
`endif
        if (!hold) begin
          if (wrap) begin
            presc_nx = '0;
            // remain<=1 also guards the unreachable remain==0 case against wrapping
            if (remain <= N'(1)) begin
              remain_nx = '0;
              state_nx  = DONE;
            end else begin
              remain_nx = remain - N'(1);
            end
          end else begin
            presc_nx = presc + PW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // Accepted start: zero duration skips straight to the end-of-interval pulse
    if (load) begin
      presc_nx = '0;
      if (duration != '0) begin
        remain_nx = duration;
        state_nx  = RUN;
      end else begin
        remain_nx = '0;
        state_nx  = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      presc  <= '0;
      remain <= '0;
      busy   <= 1'b0;
      co     <= 1'b0;
    end else begin
      state  <= state_nx;
      presc  <= presc_nx;
      remain <= remain_nx;
      busy   <= (state_nx == RUN);
      co     <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_duration_timer.sv
// Directed bench for duration_timer (PRESCALE=4, N=6) with hand-computed expectations.
module tb_duration_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] duration;
  logic       hold;
  logic       busy;
  logic [5:0] remain;
  logic       co;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned cnt;
  logic        seen;

  duration_timer #(.PRESCALE(4), .N(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .duration(duration),
    .hold(hold), .busy(busy), .remain(remain), .co(co)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; duration = '0; hold = 1'b0;
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_co", co, 0);
    chk("reset_remain", remain, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic interval, duration=3: busy after edges 0..11, co after edge 12
    start = 1'b1; duration = 6'd3;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("basic_busy", busy, 1);
      chk("basic_co_low", co, 0);
      chk("basic_remain", remain, 3 - k / 4);
      tick();
    end
    chk("basic_busy_fall", busy, 0);
    chk("basic_co", co, 1);
    chk("basic_remain_end", remain, 0);
    tick();
    chk("basic_co_once", co, 0);
    chk("basic_idle_busy", busy, 0);

    // Zero duration, with hold high to show it is ignored outside RUN
    start = 1'b1; duration = 6'd0; hold = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_co", co, 1);
    chk("zero_busy", busy, 0);
    chk("zero_remain", remain, 0);
    tick();
    hold = 1'b0;
    chk("zero_co_once", co, 0);
    chk("zero_busy_after", busy, 0);

    // Hold: duration=2, hold across edges 3..7 -> 13 busy cycles
    start = 1'b1; duration = 6'd2;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      cnt++;
      if (k == 5) chk("hold_remain_frozen", remain, 2);
      if (k == 2) hold = 1'b1;
      if (k == 7) hold = 1'b0;
      tick();
    end
    chk("hold_busy_cycles", cnt, 13);
    chk("hold_co", co, 1);
    tick();
    chk("hold_co_once", co, 0);

    // Reset mid-run: duration=5, asynchronous abort in cycle 7
    start = 1'b1; duration = 6'd5;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("rst_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_remain", remain, 0);
    chk("rst_async_co", co, 0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      seen = seen | co | busy;
      tick();
    end
    chk("rst_no_co_after", seen, 0);

    // Retrigger: duration=4, restart with duration=2 on edge 6
    start = 1'b1; duration = 6'd4;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      cnt++;
      if (k == 6) begin
        start = 1'b0;
`ifdef DURATION_TIMER_RETRIGGER_EN
        chk("retrig_remain", remain, 2);
`else
        chk("retrig_remain", remain, 3);
`endif
      end
      if (k == 5) begin
        start = 1'b1; duration = 6'd2;
      end
      tick();
    end
`ifdef DURATION_TIMER_RETRIGGER_EN
    chk("retrig_busy_cycles", cnt, 14);
`else
    chk("retrig_busy_cycles", cnt, 16);
`endif
    chk("retrig_co", co, 1);
    tick();
    chk("retrig_co_once", co, 0);

    // Back-to-back: restart with duration=1 in the DONE cycle, no IDLE gap
    start = 1'b1; duration = 6'd1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("b2b_first_busy", busy, 1);
    tick();
    chk("b2b_first_co", co, 1);
    chk("b2b_first_busy_low", busy, 0);
    start = 1'b1; duration = 6'd1;
    tick();
    start = 1'b0;
    chk("b2b_second_busy", busy, 1);
    chk("b2b_second_co_low", co, 0);
    chk("b2b_second_remain", remain, 1);
    for (int k = 0; k < 3; k++) tick();
    chk("b2b_second_busy_last", busy, 1);
    tick();
    chk("b2b_second_co", co, 1);
    chk("b2b_second_remain_end", remain, 0);
    tick();
    chk("b2b_idle_co", co, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
